// File: rtl/nine_weight_gen_if.sv
// Handshake/bus bundle for nine_weight_gen: run request in, streamed words out.
interface nine_weight_gen_if;
    logic       start;
    logic [3:0] weight;
    logic       ready;
    logic [8:0] word;
    logic       valid;
    logic       last;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] count;

    // Generator side
    modport slave (
        input  start, weight, ready,
        output word, valid, last, busy, done, err, count
    );

    // Requester / consumer side
    modport master (
        output start, weight, ready,
        input  word, valid, last, busy, done, err, count
    );
endinterface

// File: rtl/nine_weight_gen.sv
// Enumerates every 9-bit word with exactly k ones, in ascending order,
// over a valid/ready stream. One word per cycle when ready stays high.
module nine_weight_gen (
    input  logic               clk,
    input  logic               rst,
    nine_weight_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_k;
    logic [8:0] r_word;
    logic [7:0] r_count;
    logic       r_err;

    logic       w_accept;
    logic       w_bad;
    logic       w_xfer;
    logic       w_is_last;
    logic [8:0] w_shl;
    logic [8:0] w_first;
    logic [8:0] w_shr;
    logic [8:0] w_final;
    logic [8:0] w_low;
    logic [8:0] w_ripple;
    logic [8:0] w_changed;
    logic [3:0] w_pc;
    logic [3:0] w_nfill;
    logic [8:0] w_fill_shl;
    logic [8:0] w_fill;
    logic [8:0] w_succ;

    // Run request decode: only honoured in IDLE.
    assign w_accept = (r_state == IDLE) && bus.start && (bus.weight <= 4'd9);
    assign w_bad    = (r_state == IDLE) && bus.start && (bus.weight >  4'd9);
    assign w_xfer   = (r_state == EMIT) && bus.ready;

    // First word has the k low bits set; final word has the k high bits set.
    assign w_shl     = 9'h1FF << bus.weight;
    assign w_first   = ~w_shl;
    assign w_shr     = 9'h1FF >> r_k;
    assign w_final   = ~w_shr;
    assign w_is_last = (r_word == w_final);

    // Next larger word with the same popcount: add the lowest set bit to
    // ripple the lowest block of ones up by one position, then refill the
    // bottom with the ones that the carry swallowed. Never used on the final
    // word, so the ripple cannot overflow 9 bits.
    assign w_low     = r_word & (~r_word + 9'd1);
    assign w_ripple  = r_word + w_low;
    assign w_changed = r_word ^ w_ripple;

    // Popcount of the bits flipped by the ripple.
    always_comb begin
        w_pc = 4'd0;
        for (int i = 0; i < 9; i++) begin
            w_pc = w_pc + {3'b000, w_changed[i]};
        end
    end

    assign w_nfill    = w_pc - 4'd2;
    assign w_fill_shl = 9'd1 << w_nfill;
    assign w_fill     = w_fill_shl - 9'd1;
    assign w_succ     = w_ripple | w_fill;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state and stream control outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next_state = r_state;
        bus.valid    = 1'b0;
        bus.last     = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = EMIT;
            end
            EMIT: begin
                bus.valid = 1'b1;
                bus.busy  = 1'b1;
                bus.last  = w_is_last;
                if (w_xfer && w_is_last) w_next_state = FIN;
            end
            FIN: begin
                bus.done     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latched weight, current word, transfer count, error pulse.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all datapath registers are reset; outputs must read zero the
        // instant rst rises, not after the next edge.
        if (rst) begin
            r_k     <= 4'd0;
            r_word  <= 9'd0;
            r_count <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_bad;
            if (w_accept) begin
                r_k     <= bus.weight;
                r_word  <= w_first;
                r_count <= 8'd0;
            end else if (w_xfer) begin
                r_count <= r_count + 8'd1;
                if (!w_is_last) r_word <= w_succ;
            end
        end
    end

    assign bus.word  = r_word;
    assign bus.err   = r_err;
    assign bus.count = r_count;

endmodule

// File: tb/tb_nine_weight_gen.sv
// Self-checking bench for nine_weight_gen: table of full runs, random
// backpressure against a popcount-enumeration model, and corner sequences.
module tb_nine_weight_gen;

    logic clk = 1'b0;
    logic rst;

    nine_weight_gen_if bus ();

    nine_weight_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference sequence: every 9-bit value with popcount k, ascending.
    logic [8:0] exp_q[$];

    typedef struct {
        int         weight;
        int         count;
        logic [8:0] first;
        logic [8:0] fin;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_model(input int k);
        logic [8:0] v;
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            if ($countones(v) == k) exp_q.push_back(v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"},  bus.word,  0);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_last"},  bus.last,  0);
        check({tag, "_busy"},  bus.busy,  0);
        check({tag, "_done"},  bus.done,  0);
        check({tag, "_err"},   bus.err,   0);
        check({tag, "_count"}, bus.count, 0);
    endtask

    // Full run of weight k. ready_pct is the chance of ready per cycle;
    // inject_at >= 0 pulses start(weight=2) while word index inject_at is shown.
    task automatic run(input int k, input int ready_pct, input int inject_at,
                       output int n_seen, output logic [8:0] first_w, output logic [8:0] last_w);
        int         idx;
        int         cycles;
        logic       prev_hold;
        logic [8:0] prev_word;
        logic       rdy;
        build_model(k);
        n_seen    = 0;
        first_w   = 9'h0;
        last_w    = 9'h0;
        idx       = 0;
        cycles    = 0;
        prev_hold = 1'b0;
        prev_word = 9'h0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.weight = 4'(k);
        bus.ready  = 1'b0;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.weight = 4'd0;
        check("latency_valid", bus.valid, 1);
        check("latency_busy",  bus.busy,  1);
        check("start_count",   bus.count, 0);
        while (idx < exp_q.size() && cycles < 3000) begin
            bus.start  = 1'b0;
            bus.weight = 4'd0;
            check("valid_hi", bus.valid, 1);
            check("busy_hi",  bus.busy,  1);
            check("done_lo",  bus.done,  0);
            check("word",     bus.word,  exp_q[idx]);
            check("last",     bus.last,  (idx == exp_q.size() - 1) ? 1 : 0);
            check("count",    bus.count, idx);
            if (prev_hold) check("stable_word", bus.word, prev_word);
            if (idx == 0) first_w = bus.word;
            last_w = bus.word;
            if (idx == inject_at) begin
                bus.start  = 1'b1;
                bus.weight = 4'd2;
            end
            rdy       = ($urandom_range(99) < ready_pct);
            bus.ready = rdy;
            prev_hold = !rdy;
            prev_word = bus.word;
            if (rdy) begin
                n_seen++;
                idx++;
            end
            @(negedge clk);
            cycles++;
        end
        bus.ready  = 1'b0;
        bus.start  = 1'b0;
        bus.weight = 4'd0;
        check("run_completed", idx, exp_q.size());
        check("fin_valid", bus.valid, 0);
        check("fin_last",  bus.last,  0);
        check("fin_done",  bus.done,  1);
        check("fin_busy",  bus.busy,  0);
        check("fin_count", bus.count, exp_q.size());
        @(negedge clk);
        check("post_done",  bus.done,  0);
        check("post_valid", bus.valid, 0);
        check("post_count", bus.count, exp_q.size());
        check("post_word",  bus.word,  exp_q[exp_q.size() - 1]);
    endtask

    task automatic err_test(input int w, input int prev_count, input logic [8:0] prev_word);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.weight = 4'(w);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.weight = 4'd0;
        check("err_pulse", bus.err,   1);
        check("err_valid", bus.valid, 0);
        check("err_busy",  bus.busy,  0);
        check("err_count", bus.count, prev_count);
        check("err_word",  bus.word,  prev_word);
        @(negedge clk);
        check("err_one_cycle", bus.err, 0);
        for (int i = 0; i < 3; i++) begin
            check("err_no_valid", bus.valid, 0);
            check("err_no_busy",  bus.busy,  0);
            @(negedge clk);
        end
    endtask

    initial begin
        int         n;
        logic [8:0] fw;
        logic [8:0] lw;

        tbl[0] = '{0, 1,   9'h000, 9'h000};
        tbl[1] = '{1, 9,   9'h001, 9'h100};
        tbl[2] = '{2, 36,  9'h003, 9'h180};
        tbl[3] = '{3, 84,  9'h007, 9'h1C0};
        tbl[4] = '{4, 126, 9'h00F, 9'h1E0};
        tbl[5] = '{5, 126, 9'h01F, 9'h1F0};
        tbl[6] = '{6, 84,  9'h03F, 9'h1F8};
        tbl[7] = '{7, 36,  9'h07F, 9'h1FC};
        tbl[8] = '{8, 9,   9'h0FF, 9'h1FE};
        tbl[9] = '{9, 1,   9'h1FF, 9'h1FF};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.weight = 4'd0;
        bus.ready  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Every legal weight with ready held high.
        for (int i = 0; i < 10; i++) begin
            run(tbl[i].weight, 100, -1, n, fw, lw);
            check("tbl_n",     n,         tbl[i].count);
            check("tbl_first", fw,        tbl[i].first);
            check("tbl_final", lw,        tbl[i].fin);
            check("tbl_count", bus.count, tbl[i].count);
        end

        // Illegal weights: error pulse only, previous run's results untouched.
        err_test(12, 1, 9'h1FF);
        err_test(15, 1, 9'h1FF);

        // Random backpressure.
        run(4, 50, -1, n, fw, lw);
        check("rand4_n", n, 126);
        run(6, 30, -1, n, fw, lw);
        check("rand6_n", n, 84);

        // start during EMIT is ignored.
        run(3, 100, 5, n, fw, lw);
        check("inject_n",     n,  84);
        check("inject_final", lw, 9'h1C0);

        // Reset mid-run, then a fresh run.
        build_model(5);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.weight = 4'd5;
        bus.ready  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.weight = 4'd0;
        for (int i = 0; i < 10; i++) begin
            check("pre_rst_word", bus.word, exp_q[i]);
            @(negedge clk);
        end
        check("pre_rst_count", bus.count, 10);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        bus.ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_done", bus.done, 0);
            @(posedge clk);
            #1;
        end
        run(1, 100, -1, n, fw, lw);
        check("after_rst_n",     n,         9);
        check("after_rst_first", fw,        9'h001);
        check("after_rst_final", lw,        9'h100);
        check("after_rst_count", bus.count, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nine_weight_gen.md
NINE_WEIGHT_GEN -- requirements
Module: nine_weight_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new enumeration run; sampled only in IDLE.
REQ-005 weight  input  4  requested number of ones per word (legal 0..9); sampled with start.
REQ-006 ready  input  1  downstream accepts word this cycle.
REQ-007 word  output  9  current 9-bit vector whose popcount equals the latched weight.
REQ-008 valid  output  1  word is presented.
REQ-009 last  output  1  word is the final vector of the run; qualified by valid.
REQ-010 busy  output  1  high from start acceptance until the run ends.
REQ-011 done  output  1  one-cycle pulse after the last word is accepted.
REQ-012 err  output  1  one-cycle pulse when start is seen with weight > 9.
REQ-013 count  output  8  number of words accepted in the current or most recent run.

Function
REQ-014 States SHALL be IDLE, EMIT and FIN; reset SHALL enter IDLE.
REQ-015 IDLE with start=1 and weight<=9 SHALL latch weight, clear count, and go to EMIT next cycle with busy=1.
REQ-016 IDLE with start=1 and weight>9 SHALL pulse err for exactly one cycle, stay in IDLE, and leave word, valid and count unchanged.
REQ-017 start SHALL be ignored in EMIT and FIN.
REQ-018 The first word SHALL be (2^k)-1, with k the latched weight, and valid SHALL be high in the first EMIT cycle: one cycle of latency from start.
REQ-019 Words SHALL be emitted in strictly ascending numeric order; each successor is the next larger 9-bit value with popcount k.
REQ-020 Transfer: valid=1 and ready=1 on the same edge; word SHALL advance on the following edge, allowing one word per cycle back-to-back.
REQ-021 While valid=1 and ready=0, word, valid and last SHALL hold stable.
REQ-022 In EMIT, valid SHALL stay high until the last word transfers and SHALL never drop mid-run.
REQ-023 last SHALL be high only when word = ((2^k)-1) << (9-k).
REQ-024 For k=0 and k=9, the run SHALL be a single word (0x000 and 0x1FF respectively) with last=1.
REQ-025 count SHALL increment by one per transfer; at run end it SHALL equal C(9,k) (max 126); it SHALL hold until the next accepted start.
REQ-026 The last transfer SHALL move to FIN, with valid=0 and last=0 on the next cycle.
REQ-027 FIN SHALL assert done for one cycle, deassert busy, and return to IDLE.
REQ-028 word SHALL never wrap past 0x1FF, and no word with popcount != k SHALL appear with valid=1.
REQ-029 When valid=0, word SHALL hold its last value.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE, word=0, valid=0, last=0, busy=0, done=0, err=0 and count=0, independent of clk.
REQ-031 Reset mid-run SHALL abandon the run with no done pulse, and the block SHALL accept a new start on the first edge after rst deasserts.

Verification
REQ-032 weight=3, ready=1 constant -> valid at cycle 1 after start; 84 consecutive words, first 0x007, last 0x1C0; last high only on 0x1C0; done one cycle later; count=84.
REQ-033 weight=0 -> single word 0x000 with last=1 and count=1; weight=9 -> single word 0x1FF with last=1 and count=1.
REQ-034 weight=12 -> err pulses one cycle, valid never rises, busy stays 0, count unchanged.
REQ-035 weight=4 with ready random (about 50%) -> word stable whenever ready=0; 126 unique ascending words, each popcount 4; done once.
REQ-036 weight=5, rst asserted after 10 transfers -> outputs zero immediately, no done; a new start with weight=1 -> words 0x001, 0x002, ..., 0x100 and count=9.
REQ-037 start pulsed during EMIT with weight=2 -> ignored; the run continues with the original weight and its word count is unaffected.
